cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Two-master arbiter that shares one memory-side port between the instruction cache and the data cache. Each cache's memory-side port (address, write data, write enable, request, byte enable, read data, grant, read valid, error) connects to the arbiter, and the arbiter's single port drives the SoC memory/bus. At most one transaction is outstanding at a time. Arbitration is round-robin or fixed-priority, and an optional response timeout returns an error instead of hanging a cache.

## Interface
Parameters:
- `POLICY`, default 0: 0 = round-robin, 1 = fixed priority (m0 always wins).
- `TIMEOUT_CYCLES`, default 0: cycles allowed in WAIT before a synthetic error response; 0 disables the timeout.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-low; all state is cleared on the `clk` edge while `reset`=0.
- `m0_addr_i`, `m1_addr_i` in 32: request address.
- `m0_wdata_i`, `m1_wdata_i` in 32: write data.
- `m0_we_i`, `m1_we_i` in 1: write enable.
- `m0_req_i`, `m1_req_i` in 1: request; held until granted.
- `m0_be_i`, `m1_be_i` in 4: byte enables.
- `m0_rdata_o`, `m1_rdata_o` out 32: response data.
- `m0_gnt_o`, `m1_gnt_o` out 1: request accepted.
- `m0_rvalid_o`, `m1_rvalid_o` out 1: response valid.
- `m0_error_o`, `m1_error_o` out 1: response error; qualified by `rvalid`.
- `mem_addr_o` out 32, `mem_wdata_o` out 32, `mem_we_o` out 1, `mem_req_o` out 1, `mem_be_o` out 4: memory-side request.
- `mem_rdata_i` in 32, `mem_gnt_i` in 1, `mem_rvalid_i` in 1, `mem_error_i` in 1: memory-side response.
- `owner_o` out 1: index of the current or last owner.
- `busy_o` out 1: high when the state is not IDLE.
- `timeout_o` out 1: sticky; set on timeout or on a stray `mem_rvalid_i`.

## Operation
States:
- **IDLE**
  - Combinationally pick a winner among the asserted `req` inputs.
  - Round-robin: the master that was not the last owner wins a tie.
  - Forward the winner's addr/wdata/we/be/req to the mem port in the same cycle.
  - `mem_gnt_i`=1: assert the winner's `gnt` the same cycle, latch owner, go to WAIT.
  - `mem_gnt_i`=0: latch owner, go to HOLD.
  - No `req` asserted: all mem outputs are 0.
- **HOLD**
  - Keep forwarding the owner's signals only; the other master's req is ignored, so there is no preemption.
  - `mem_gnt_i`=1: owner `gnt`=1, go to WAIT.
  - Owner deasserts `req`: return to IDLE without a transaction.
- **WAIT**
  - `mem_req_o`=0; the timeout counter increments each cycle.
  - `mem_rvalid_i`=1: drive the owner's `rvalid`=1 with `rdata`=`mem_rdata_i` and `error`=`mem_error_i`, record the owner as last, go to IDLE.
  - Counter reaches `TIMEOUT_CYCLES` (when nonzero): owner `rvalid`=1, `error`=1, `rdata`=0; set `timeout_o`; go to IDLE.

Routing and corner cases:
- Non-owners always see `gnt`, `rvalid`, `error`=0 and `rdata`=0.
- `mem_rvalid_i` outside WAIT is dropped and sets `timeout_o`.
- Once a timeout has fired, the memory must never answer that request. A late response would be misattributed to the next transaction; this is a documented limitation.
- Fixed priority (`POLICY`=1): the last-owner record is still kept but does not affect selection.

## Timing
- Reset (`reset`=0 at a clk edge):
  - State goes to IDLE, counter to 0, last owner to 1 (so m0 wins the first tie).
  - `owner_o`=0, `timeout_o`=0, `busy_o`=0.
  - With no `req` asserted, all `m*_gnt/rvalid/error/rdata` and all `mem_*` outputs are 0.
- Request path is combinational, with zero added latency: req→mem_req and mem_gnt→m_gnt in the same cycle.
- Response path is combinational: mem_rvalid→m_rvalid in the same cycle.
- Back-to-back: after `rvalid`, the next arbitration happens in the following cycle in IDLE. That gives a minimum of 1 cycle between transactions.
- Simultaneous `mem_rvalid_i` and timeout expiry in the same cycle: the real response wins, `error`=`mem_error_i`, and `timeout_o` is not set.
- Reset asserted mid-transaction aborts it. Neither master receives `rvalid`, and a later `mem_rvalid_i` counts as stray.
- The counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide, saturates, and clears on entry to WAIT.

## Structure
- The shared package `cache_pkg` holds:
  - the state enum {IDLE, HOLD, WAIT};
  - the master index type;
  - the `POLICY_RR` / `POLICY_FIXED` constants.
- Sub-module `rr_pick2`: combinational winner select from the two reqs, last owner and policy. Everything else stays in the top module.

## Test plan
- **Single read**: m0 reads 0x0000_1000; mem grants immediately and returns 0xDEADBEEF after 3 cycles → m0 `gnt` in cycle 0, m0 `rvalid` with 0xDEADBEEF in cycle 3, m1 outputs all 0.
- **Round-robin tie**: both masters request continuously; mem grants each cycle with 1-cycle rvalid → the grant order is m0, m1, m0, m1 and `owner_o` toggles accordingly.
- **HOLD, no preemption**: m1 requests, `mem_gnt_i`=0 for 4 cycles, then m0 requests → m1 stays owner and mem_addr stays m1's address until gnt; m0 is served afterwards.
- **Timeout**: `TIMEOUT_CYCLES`=8, mem never sends rvalid → m0 `rvalid`=1, `error`=1, `rdata`=0 at WAIT cycle 8; `timeout_o` sticks at 1 until reset.
- **Write pass-through**: m1 writes 0x1234_5678 to 0x0000_2004 with be=0xF → mem sees the same addr/wdata/we=1/be in the grant cycle; m1 `rvalid` returns with `error`=`mem_error_i`=1.
- **Reset mid-WAIT**: `reset`=0 for 1 cycle during WAIT, then `mem_rvalid_i` pulses → no master `rvalid`; `timeout_o`=1; the next m0 request proceeds normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the two-master cache memory arbiter.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Index of a requesting master: 0 = instruction cache, 1 = data cache.
    typedef logic midx_t;

    localparam int POLICY_RR    = 0;
    localparam int POLICY_FIXED = 1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of both cache-side ports, the shared memory-side port and arbiter status.
interface cache_mem_arbiter_if;

    logic [31:0] m0_addr_i,  m1_addr_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic        m0_we_i,    m1_we_i;
    logic        m0_req_i,   m1_req_i;
    logic [3:0]  m0_be_i,    m1_be_i;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_gnt_o,   m1_gnt_o;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic        m0_error_o, m1_error_o;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_we_o;
    logic        mem_req_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic        mem_error_i;

    logic        owner_o;
    logic        busy_o;
    logic        timeout_o;

    // Arbiter side.
    modport slave (
        input  m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i, m0_we_i, m1_we_i,
               m0_req_i, m1_req_i, m0_be_i, m1_be_i,
               mem_rdata_i, mem_gnt_i, mem_rvalid_i, mem_error_i,
        output m0_rdata_o, m1_rdata_o, m0_gnt_o, m1_gnt_o,
               m0_rvalid_o, m1_rvalid_o, m0_error_o, m1_error_o,
               mem_addr_o, mem_wdata_o, mem_we_o, mem_req_o, mem_be_o,
               owner_o, busy_o, timeout_o
    );

    // Environment side: both caches plus the memory.
    modport master (
        output m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i, m0_we_i, m1_we_i,
               m0_req_i, m1_req_i, m0_be_i, m1_be_i,
               mem_rdata_i, mem_gnt_i, mem_rvalid_i, mem_error_i,
        input  m0_rdata_o, m1_rdata_o, m0_gnt_o, m1_gnt_o,
               m0_rvalid_o, m1_rvalid_o, m0_error_o, m1_error_o,
               mem_addr_o, mem_wdata_o, mem_we_o, mem_req_o, mem_be_o,
               owner_o, busy_o, timeout_o
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational winner select between two requesters, round-robin or fixed priority.
module rr_pick2
    import cache_pkg::*;
#(
    parameter int POLICY = POLICY_RR
) (
    input  logic  req0,
    input  logic  req1,
    input  midx_t last,
    output logic  valid,
    output midx_t winner
);

    assign valid = req0 | req1;

    // On a tie round-robin favours whoever was not served last.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = (POLICY == POLICY_FIXED) ? 1'b0 : ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between the I-cache (m0) and D-cache (m1), one transaction at a time.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int POLICY         = POLICY_RR,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset,
    cache_mem_arbiter_if.slave bus
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t        state_reg, state_next;
    midx_t         owner_reg, owner_next;
    midx_t         last_reg, last_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          timeout_reg, timeout_next;

    logic          pick_valid;
    midx_t         pick;
    midx_t         sel;
    logic          fwd;
    logic          owner_req;
    logic          expire;
    logic          gnt, rvalid, err;
    logic [31:0]   rdata;

    rr_pick2 #(.POLICY(POLICY)) u_pick (
        .req0   (bus.m0_req_i),
        .req1   (bus.m1_req_i),
        .last   (last_reg),
        .valid  (pick_valid),
        .winner (pick)
    );

    assign owner_req = owner_reg ? bus.m1_req_i : bus.m0_req_i;
    // cnt_reg counts completed WAIT cycles, so this fires in WAIT cycle TIMEOUT_CYCLES.
    assign expire    = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST);

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
        sel          = owner_reg;
        fwd          = 1'b0;
        gnt          = 1'b0;
        rvalid       = 1'b0;
        err          = 1'b0;
        rdata        = '0;

        if (bus.mem_rvalid_i && state_reg != WAIT) begin
            timeout_next = 1'b1;
        end

        unique case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    sel        = pick;
                    fwd        = 1'b1;
                    owner_next = pick;
                    if (bus.mem_gnt_i) begin
                        gnt        = 1'b1;
                        cnt_next   = '0;
                        state_next = WAIT;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // Only the locked-in owner is considered until memory grants it.
                fwd = owner_req;
                if (!owner_req) begin
                    state_next = IDLE;
                end else if (bus.mem_gnt_i) begin
                    gnt        = 1'b1;
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    rvalid     = 1'b1;
                    rdata      = bus.mem_rdata_i;
                    err        = bus.mem_error_i;
                    last_next  = owner_reg;
                    state_next = IDLE;
                end else if (expire) begin
                    rvalid       = 1'b1;
                    err          = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            owner_reg   <= 1'b0;
            last_reg    <= 1'b1;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign bus.mem_req_o   = fwd;
    assign bus.mem_addr_o  = !fwd ? '0 : (sel ? bus.m1_addr_i  : bus.m0_addr_i);
    assign bus.mem_wdata_o = !fwd ? '0 : (sel ? bus.m1_wdata_i : bus.m0_wdata_i);
    assign bus.mem_we_o    = fwd & (sel ? bus.m1_we_i : bus.m0_we_i);
    assign bus.mem_be_o    = !fwd ? '0 : (sel ? bus.m1_be_i : bus.m0_be_i);

    assign bus.m0_gnt_o    = gnt    & (sel == 1'b0);
    assign bus.m1_gnt_o    = gnt    & (sel == 1'b1);
    assign bus.m0_rvalid_o = rvalid & (sel == 1'b0);
    assign bus.m1_rvalid_o = rvalid & (sel == 1'b1);
    assign bus.m0_error_o  = err    & (sel == 1'b0);
    assign bus.m1_error_o  = err    & (sel == 1'b1);
    assign bus.m0_rdata_o  = (sel == 1'b0) ? rdata : '0;
    assign bus.m1_rdata_o  = (sel == 1'b1) ? rdata : '0;

    assign bus.owner_o     = owner_reg;
    assign bus.busy_o      = (state_reg != IDLE);
    assign bus.timeout_o   = timeout_reg;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench: per-cycle vector table plus hand sequences, responses checked via a scoreboard queue.
module tb_cache_mem_arbiter;

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2004;
    localparam logic [31:0] Z  = 32'h0;

    typedef struct {
        logic        m0r, m1r, gnt, rv;
        logic [31:0] rd;
        logic        rsp;
        logic [1:0]  eg;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eown, ebusy;
    } vec_t;

    typedef struct packed {
        logic        m;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    rsp_t sb[$];
    vec_t vecs[$];

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter #(.POLICY(0), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic m0r, input logic m1r, input logic gnt, input logic rv,
                                 input logic [31:0] rd, input logic rsp, input logic [1:0] eg,
                                 input logic ereq, input logic [31:0] eaddr, input logic eown,
                                 input logic ebusy);
        vec_t v;
        v.m0r = m0r; v.m1r = m1r; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rsp = rsp;
        v.eg = eg; v.ereq = ereq; v.eaddr = eaddr; v.eown = eown; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m0r, input logic m1r, input logic gnt, input logic rv,
                         input logic err, input logic [31:0] rd);
        bus.m0_req_i     = m0r;
        bus.m1_req_i     = m1r;
        bus.mem_gnt_i    = gnt;
        bus.mem_rvalid_i = rv;
        bus.mem_error_i  = err;
        bus.mem_rdata_i  = rd;
    endtask

    task automatic push(input logic m, input logic [31:0] data, input logic err);
        sb.push_back({m, data, err});
    endtask

    // Let combinational outputs settle, then match any response against the scoreboard.
    task automatic settle();
        rsp_t        e;
        logic [1:0]  er;
        logic [31:0] ed;
        logic        ee;
        #3;
        if (bus.m0_rvalid_o || bus.m1_rvalid_o || sb.size() != 0) begin
            er = 2'b00; ed = Z; ee = 1'b0;
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                er = e.m ? 2'b10 : 2'b01;
                ed = e.data;
                ee = e.err;
            end
            $display("rsp: rvalid{m1,m0}=%b m0_rdata=%08h m1_rdata=%08h err{m1,m0}=%b%b",
                     {bus.m1_rvalid_o, bus.m0_rvalid_o}, bus.m0_rdata_o, bus.m1_rdata_o,
                     bus.m1_error_o, bus.m0_error_o);
            check("rsp_valid", 32'({bus.m1_rvalid_o, bus.m0_rvalid_o}), 32'(er));
            check("rsp_data",  er[1] ? bus.m1_rdata_o : bus.m0_rdata_o, ed);
            check("rsp_error", 32'(er[1] ? bus.m1_error_o : bus.m0_error_o), 32'(ee));
            check("rsp_other_data", er[1] ? bus.m0_rdata_o : bus.m1_rdata_o, Z);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            drive(L, L, L, L, L, Z);
            settle();
            adv();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.m0_addr_i = A0; bus.m0_wdata_i = 32'hA5A5_5A5A; bus.m0_we_i = 1'b0; bus.m0_be_i = 4'h3;
        bus.m1_addr_i = A1; bus.m1_wdata_i = 32'h1234_5678; bus.m1_we_i = 1'b1; bus.m1_be_i = 4'hF;
        drive(L, L, L, L, L, Z);

        // m0r m1r gnt rv rdata rsp {g1,g0} mem_req mem_addr owner busy
        vecs.push_back(mkv(H, H, H, L, Z,            L, 2'b01, H, A0, L, L)); // tie -> m0
        vecs.push_back(mkv(H, H, H, H, 32'h1111_0000, H, 2'b00, L, Z,  L, H));
        vecs.push_back(mkv(H, H, H, L, Z,            L, 2'b10, H, A1, L, L)); // tie -> m1
        vecs.push_back(mkv(H, H, H, H, 32'h2222_0001, H, 2'b00, L, Z,  H, H));
        vecs.push_back(mkv(H, H, H, L, Z,            L, 2'b01, H, A0, H, L)); // tie -> m0
        vecs.push_back(mkv(H, H, H, H, 32'h3333_0002, H, 2'b00, L, Z,  L, H));
        vecs.push_back(mkv(H, H, H, L, Z,            L, 2'b10, H, A1, L, L)); // tie -> m1
        vecs.push_back(mkv(H, H, H, H, 32'h4444_0003, H, 2'b00, L, Z,  H, H));
        vecs.push_back(mkv(H, L, H, L, Z,            L, 2'b01, H, A0, H, L)); // single read
        vecs.push_back(mkv(L, L, L, L, Z,            L, 2'b00, L, Z,  L, H));
        vecs.push_back(mkv(L, L, L, L, Z,            L, 2'b00, L, Z,  L, H));
        vecs.push_back(mkv(L, L, L, H, 32'hDEAD_BEEF, H, 2'b00, L, Z,  L, H));
        vecs.push_back(mkv(L, H, L, L, Z,            L, 2'b00, H, A1, L, L)); // m1 -> HOLD
        vecs.push_back(mkv(L, H, L, L, Z,            L, 2'b00, H, A1, H, H));
        vecs.push_back(mkv(H, H, L, L, Z,            L, 2'b00, H, A1, H, H)); // m0 must not preempt
        vecs.push_back(mkv(H, H, L, L, Z,            L, 2'b00, H, A1, H, H));
        vecs.push_back(mkv(H, H, H, L, Z,            L, 2'b10, H, A1, H, H));
        vecs.push_back(mkv(H, L, L, H, 32'h5555_AAAA, H, 2'b00, L, Z,  H, H));
        vecs.push_back(mkv(H, L, H, L, Z,            L, 2'b01, H, A0, H, L)); // m0 served after
        vecs.push_back(mkv(L, L, L, H, 32'h6666_0000, H, 2'b00, L, Z,  L, H));
        vecs.push_back(mkv(L, H, L, L, Z,            L, 2'b00, H, A1, L, L)); // HOLD then withdraw
        vecs.push_back(mkv(L, L, H, L, Z,            L, 2'b00, L, Z,  H, H));
        vecs.push_back(mkv(L, L, L, L, Z,            L, 2'b00, L, Z,  H, L));

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        settle();
        check("rst_owner",   32'(bus.owner_o),   32'(1'b0));
        check("rst_busy",    32'(bus.busy_o),    32'(1'b0));
        check("rst_timeout", 32'(bus.timeout_o), 32'(1'b0));
        check("rst_mem_req", 32'(bus.mem_req_o), 32'(1'b0));
        check("rst_mem_addr", bus.mem_addr_o, Z);
        check("rst_gnt", 32'({bus.m1_gnt_o, bus.m0_gnt_o}), 32'(2'b00));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.m0r, v.m1r, v.gnt, v.rv, L, v.rd);
            if (v.rsp) push(v.eown, v.rd, L);
            settle();
            check($sformatf("v%0d_gnt", i),   32'({bus.m1_gnt_o, bus.m0_gnt_o}), 32'(v.eg));
            check($sformatf("v%0d_mreq", i),  32'(bus.mem_req_o), 32'(v.ereq));
            check($sformatf("v%0d_maddr", i), bus.mem_addr_o, v.eaddr);
            check($sformatf("v%0d_owner", i), 32'(bus.owner_o), 32'(v.eown));
            check($sformatf("v%0d_busy", i),  32'(bus.busy_o), 32'(v.ebusy));
            adv();
        end

        // Write pass-through with error response
        drive(L, H, H, L, L, Z);
        settle();
        $display("write: addr=%08h wdata=%08h we=%b be=%h", bus.mem_addr_o, bus.mem_wdata_o,
                 bus.mem_we_o, bus.mem_be_o);
        check("wr_addr",  bus.mem_addr_o, A1);
        check("wr_wdata", bus.mem_wdata_o, 32'h1234_5678);
        check("wr_we",    32'(bus.mem_we_o), 32'(1'b1));
        check("wr_be",    32'(bus.mem_be_o), 32'(4'hF));
        check("wr_gnt",   32'({bus.m1_gnt_o, bus.m0_gnt_o}), 32'(2'b10));
        adv();
        drive(L, L, L, H, H, 32'h0BAD_0BAD);
        push(H, 32'h0BAD_0BAD, H);
        settle();
        adv();

        // Real response arriving in the same cycle the timeout would fire
        drive(H, L, H, L, L, Z);
        settle();
        check("sim_gnt", 32'(bus.m0_gnt_o), 32'(1'b1));
        adv();
        idle_cycles(7);
        drive(L, L, L, H, L, 32'h7777_7777);
        push(L, 32'h7777_7777, L);
        settle();
        adv();
        idle_cycles(1);
        check("sim_timeout", 32'(bus.timeout_o), 32'(1'b0));
        check("sim_busy",    32'(bus.busy_o),    32'(1'b0));

        // Timeout: memory never answers
        drive(H, L, H, L, L, Z);
        settle();
        check("to_gnt", 32'(bus.m0_gnt_o), 32'(1'b1));
        adv();
        idle_cycles(7);
        drive(L, L, L, L, L, Z);
        push(L, Z, H);
        settle();
        adv();
        for (int k = 0; k < 3; k++) begin
            idle_cycles(1);
            check($sformatf("to_sticky%0d", k), 32'(bus.timeout_o), 32'(1'b1));
        end
        check("to_busy", 32'(bus.busy_o), 32'(1'b0));

        // Reset in the middle of WAIT, then a stray response
        drive(H, L, H, L, L, Z);
        settle();
        adv();
        drive(L, L, L, L, L, Z);
        reset = 1'b0;
        settle();
        adv();
        reset = 1'b1;
        drive(L, L, L, H, L, 32'h0000_0099);
        settle();
        check("rw_timeout_cleared", 32'(bus.timeout_o), 32'(1'b0));
        check("rw_busy",  32'(bus.busy_o),  32'(1'b0));
        check("rw_owner", 32'(bus.owner_o), 32'(1'b0));
        adv();
        idle_cycles(1);
        check("rw_stray_timeout", 32'(bus.timeout_o), 32'(1'b1));
        drive(H, L, H, L, L, Z);
        settle();
        check("rw_gnt",   32'({bus.m1_gnt_o, bus.m0_gnt_o}), 32'(2'b01));
        check("rw_maddr", bus.mem_addr_o, A0);
        adv();
        drive(L, L, L, H, L, 32'hCAFE_F00D);
        push(L, 32'hCAFE_F00D, L);
        settle();
        adv();
        idle_cycles(1);
        check("rw_done_busy", 32'(bus.busy_o), 32'(1'b0));

        check("sb_empty", 32'(sb.size()), Z);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
